// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC selection, synchronous IMEM read issue,
// and a small shift-register instruction buffer feeding the IF/ID boundary.
// The buffer head is held in flops so IF_PC/IF_IR/IF_VALID come straight
// from registers. A credit check on (buffer + in-flight) keeps the buffer from
// overflowing, so decode may stall for any number of cycles without losing or
// duplicating a fetch.

module fetch_stage_checker #(
  parameter int FIFO_DEPTH = 2,
  parameter int CW         = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count
);

  // A response may only land in a full buffer when the head leaves in the same cycle.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter int              IMEM_AW    = 14,
  parameter logic [XLEN-1:0] RESET_VEC  = {XLEN{1'b0}},
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [1:0]         PC_SEL,
  input  logic [XLEN-1:0]    JALR_TGT,
  input  logic [XLEN-1:0]    BR_TGT,
  input  logic [XLEN-1:0]    JAL_TGT,
  input  logic               STALL,
  output logic               IMEM_RDEN,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  input  logic [31:0]        IMEM_DATA,
  output logic [XLEN-1:0]    IF_PC,
  output logic [31:0]        IF_IR,
  output logic               IF_VALID,
  output logic               MISALIGN
);

  // Counter width able to hold 0..FIFO_DEPTH.
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fetch_stage: FIFO_DEPTH must be at least 2");
  end
  if (XLEN < IMEM_AW + 2) begin : g_bad_xlen
    $error("fetch_stage: XLEN too small for IMEM_AW");
  end

  // Architectural state.
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] req_pc_r;
  logic            inflight_r;
  logic [CW-1:0]   count_r;
  logic            valid_r;
  logic            misalign_r;
  logic [XLEN-1:0] buf_pc_r [FIFO_DEPTH];
  logic [31:0]     buf_ir_r [FIFO_DEPTH];

  // Combinational control.
  logic            redirect_s;
  logic [XLEN-1:0] target_s;
  logic            pop_s;
  logic            push_s;
  logic            credit_s;
  logic            issue_s;
  logic [CW:0]     occupancy_s;
  logic [CW:0]     limit_s;
  logic [CW-1:0]   count_nxt_s;
  logic [CW-1:0]   wr_idx_s;
  logic [XLEN-1:0] buf_pc_nxt_s [FIFO_DEPTH];
  logic [31:0]     buf_ir_nxt_s [FIFO_DEPTH];

  // Redirect detection and target selection from the PC-select code.
  always_comb begin
    redirect_s = (PC_SEL != 2'b00);
    case (PC_SEL)
      2'b01:   target_s = JALR_TGT;
      2'b10:   target_s = BR_TGT;
      2'b11:   target_s = JAL_TGT;
      default: target_s = pc_r;
    endcase
  end

  // Consume/fill handshake and the issue credit (buffer + in-flight vs depth).
  always_comb begin
    pop_s       = valid_r & ~STALL & ~redirect_s;
    push_s      = inflight_r & ~redirect_s;
    occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    limit_s     = (CW+1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop_s};
    credit_s    = (occupancy_s < limit_s);
    issue_s     = RST_N & ~redirect_s & credit_s;
  end

  // Occupancy update and the slot that receives a returning instruction.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
    wr_idx_s = count_r - {{(CW-1){1'b0}}, pop_s};
  end

  // Shift the buffer toward the head on pop, then drop the response into its slot.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      buf_pc_nxt_s[i] = pop_s ? buf_pc_r[(i + 1) % FIFO_DEPTH] : buf_pc_r[i];
      buf_ir_nxt_s[i] = pop_s ? buf_ir_r[(i + 1) % FIFO_DEPTH] : buf_ir_r[i];
      buf_pc_nxt_s[i] = (push_s && (wr_idx_s == CW'(i))) ? req_pc_r  : buf_pc_nxt_s[i];
      buf_ir_nxt_s[i] = (push_s && (wr_idx_s == CW'(i))) ? IMEM_DATA : buf_ir_nxt_s[i];
    end
  end

  // PC register and the single outstanding IMEM request.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_r       <= RESET_VEC;
      req_pc_r   <= {XLEN{1'b0}};
      inflight_r <= 1'b0;
    end else if (redirect_s) begin
      pc_r       <= {target_s[XLEN-1:2], 2'b00};
      inflight_r <= 1'b0;
    end else if (issue_s) begin
      pc_r       <= pc_r + PC_STEP;
      req_pc_r   <= pc_r;
      inflight_r <= 1'b1;
    end else begin
      inflight_r <= 1'b0;
    end
  end

  // Instruction buffer storage; a redirect leaves contents but empties the count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc_r[i] <= {XLEN{1'b0}};
        buf_ir_r[i] <= 32'h0000_0000;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_pc_r[i] <= buf_pc_nxt_s[i];
        buf_ir_r[i] <= buf_ir_nxt_s[i];
      end
    end
  end

  // Occupancy, registered head-valid flag and the misaligned-target pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      misalign_r <= 1'b0;
    end else if (redirect_s) begin
      count_r    <= {CW{1'b0}};
      valid_r    <= 1'b0;
      misalign_r <= (target_s[1:0] != 2'b00);
    end else begin
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != {CW{1'b0}});
      misalign_r <= 1'b0;
    end
  end

  assign IMEM_RDEN = issue_s;
  assign IMEM_ADDR = pc_r[IMEM_AW+1:2];
  assign IF_PC     = buf_pc_r[0];
  assign IF_IR     = buf_ir_r[0];
  assign IF_VALID  = valid_r;
  assign MISALIGN  = misalign_r;

  fetch_stage_checker #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CW         (CW)
  ) u_checker (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_r)
  );

endmodule
